// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the systolic-unit sequencer.
package tpu_seq_pkg;

  localparam int DEF_DIM  = 32;
  localparam int LAST_IDX = DEF_DIM - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_RD_ADDR = 3'd5,
    S_RD_DATA = 3'd6,
    S_OUT     = 3'd7
  } state_t;

endpackage

// File: rtl/tpu_idx_cnt.sv
// Row-major row/col walker shared by the load and read-out phases.
module tpu_idx_cnt
  import tpu_seq_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int LAST  = LAST_IDX
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] LAST_V = IDX_W'(LAST);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Explicit wrap at LAST so non-power-of-two dimensions also return to 0.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == LAST_V) begin
        col_d = '0;
        row_d = (row_q == LAST_V) ? '0 : row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == LAST_V) && (col_q == LAST_V);

endmodule

// File: rtl/tpu_seq.sv
// Runs one full A/B load, start/done handshake and C read-out per accepted command.
module tpu_seq
  import tpu_seq_pkg::*;
#(
  parameter int DIM    = DEF_DIM,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              abort_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              tpu_start_o,
  output logic              tpu_wr_a_o,
  output logic              tpu_wr_b_o,
  output logic              tpu_wr_c_o,
  output logic [IDX_W-1:0]  tpu_row_o,
  output logic [IDX_W-1:0]  tpu_col_o,
  output logic [DATA_W-1:0] tpu_data_o,
  input  logic [DATA_W-1:0] tpu_data_i,
  input  logic              tpu_done_i,
  output logic              busy_o,
  output logic              done_o
);

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              cnt_clr, cnt_inc, cnt_last;
  logic              wr_a, wr_b, done;
  logic [IDX_W-1:0]  row, col;

  tpu_idx_cnt #(
    .IDX_W (IDX_W),
    .LAST  (DIM - 1)
  ) u_idx_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .row_o   (row),
    .col_o   (col),
    .last_o  (cnt_last)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    wr_a        = 1'b0;
    wr_b        = 1'b0;
    done        = 1'b0;
    if (abort_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_clr     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            state_d = S_LOAD_A;
            cnt_clr = 1'b1;
          end
        end
        S_LOAD_A: begin
          if (in_valid_i) begin
            wr_a    = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_last) state_d = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_valid_i) begin
            wr_b    = 1'b1;
            cnt_inc = 1'b1;
            if (cnt_last) state_d = S_START;
          end
        end
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (tpu_done_i) state_d = S_RD_ADDR;
        end
        S_RD_ADDR: state_d = S_RD_DATA;
        // Unit read is registered: data for the RD_ADDR address is valid now.
        S_RD_DATA: begin
          out_data_d  = tpu_data_i;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_d = 1'b0;
            cnt_inc     = 1'b1;
            if (cnt_last) begin
              done    = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_ADDR;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign in_ready_o  = ((state_q == S_LOAD_A) || (state_q == S_LOAD_B)) && !abort_i;
  // Unit start is level-sensitive, so it stays high until done arrives.
  assign tpu_start_o = (state_q == S_START) || (state_q == S_WAIT);
  assign tpu_wr_a_o  = wr_a;
  assign tpu_wr_b_o  = wr_b;
  assign tpu_wr_c_o  = 1'b0;
  assign tpu_row_o   = row;
  assign tpu_col_o   = col;
  assign tpu_data_o  = (wr_a || wr_b) ? in_data_i : '0;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign done_o      = done;

endmodule

// File: tb/tb_tpu_seq.sv
// Scoreboard bench for tpu_seq at DIM=4 with a behavioural systolic-unit model.
module tb_tpu_seq;

  localparam int DIM = 4;
  localparam int N   = DIM * DIM;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, abort = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        cmd_ready, in_ready, out_valid, busy_o, done_o;
  logic [31:0] out_data, tpu_data_o;
  logic        tpu_start, tpu_wr_a, tpu_wr_b, tpu_wr_c;
  logic [1:0]  tpu_row, tpu_col;
  logic [31:0] tpu_rdata = '0;
  logic        tpu_done = 1'b0;

  int errors = 0, checks = 0;
  int wr_a_cnt = 0, wr_b_cnt = 0, done_cnt = 0, start_cnt = 0;
  logic start_prev = 1'b0;
  beat_t exp_a[$], exp_b[$], exp_c[$];
  logic [31:0] a_v[N], b_v[N];

  always #5 clk = ~clk;

  tpu_seq #(.DIM(DIM), .IDX_W(2), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .abort_i(abort), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .tpu_start_o(tpu_start), .tpu_wr_a_o(tpu_wr_a), .tpu_wr_b_o(tpu_wr_b),
    .tpu_wr_c_o(tpu_wr_c), .tpu_row_o(tpu_row), .tpu_col_o(tpu_col),
    .tpu_data_o(tpu_data_o), .tpu_data_i(tpu_rdata), .tpu_done_i(tpu_done),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Unit model: 16-bit operand storage, done 10 cycles into start, registered read.
  logic [15:0] mem_a[DIM][DIM], mem_b[DIM][DIM];
  int tcnt = 0;

  function automatic logic [31:0] c_of(input int r, input int c);
    logic [31:0] s = '0;
    for (int k = 0; k < DIM; k++) s = s + 32'(mem_a[r][k]) * 32'(mem_b[k][c]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 0;
      tpu_done <= 1'b0;
      tpu_rdata <= '0;
    end else begin
      if (tpu_wr_a) mem_a[tpu_row][tpu_col] <= tpu_data_o[15:0];
      if (tpu_wr_b) mem_b[tpu_row][tpu_col] <= tpu_data_o[15:0];
      if (tpu_start) begin
        tcnt <= tcnt + 1;
        if (tcnt >= 9) tpu_done <= 1'b1;
      end else begin
        tcnt <= 0;
        tpu_done <= 1'b0;
      end
      tpu_rdata <= c_of(int'(tpu_row), int'(tpu_col));
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (tpu_wr_a) begin
        wr_a_cnt++;
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL wr_a_unexpected row=%0d col=%0d", tpu_row, tpu_col);
        end else begin
          e = exp_a.pop_front();
          if (int'(tpu_row) !== e.row || int'(tpu_col) !== e.col || tpu_data_o !== e.data) begin
            errors++;
            $display("FAIL wr_a got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tpu_row, tpu_col, tpu_data_o, e.row, e.col, e.data);
          end
        end
      end
      if (tpu_wr_b) begin
        wr_b_cnt++;
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL wr_b_unexpected row=%0d col=%0d", tpu_row, tpu_col);
        end else begin
          e = exp_b.pop_front();
          if (int'(tpu_row) !== e.row || int'(tpu_col) !== e.col || tpu_data_o !== e.data) begin
            errors++;
            $display("FAIL wr_b got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tpu_row, tpu_col, tpu_data_o, e.row, e.col, e.data);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_c.size() == 0) begin
          errors++;
          $display("FAIL c_unexpected data=%0d", out_data);
        end else begin
          e = exp_c.pop_front();
          if (int'(tpu_row) !== e.row || int'(tpu_col) !== e.col || out_data !== e.data) begin
            errors++;
            $display("FAIL c_out got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tpu_row, tpu_col, out_data, e.row, e.col, e.data);
          end
        end
      end
      if (done_o) begin
        done_cnt++;
        checks++;
        if (exp_c.size() != 0 || !(out_valid && out_ready)) begin
          errors++;
          $display("FAIL done_early remaining=%0d hs=%0b want 0 and 1", exp_c.size(), out_valid && out_ready);
        end
      end
      if (tpu_start && !start_prev) start_cnt++;
      start_prev = tpu_start;
    end else begin
      start_prev = 1'b0;
    end
  end

  task automatic send_cmd();
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_c();
    beat_t e;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        e.row = r; e.col = c; e.data = '0;
        for (int k = 0; k < DIM; k++)
          e.data = e.data + 32'(a_v[r*DIM+k][15:0]) * 32'(b_v[k*DIM+c][15:0]);
        exp_c.push_back(e);
      end
  endtask

  task automatic load_mat(input bit is_b, input bit gaps, input int nbeats);
    beat_t e;
    int i = 0, cyc = 0;
    for (int j = 0; j < nbeats; j++) begin
      e.row = j / DIM; e.col = j % DIM; e.data = is_b ? b_v[j] : a_v[j];
      if (is_b) exp_b.push_back(e); else exp_a.push_back(e);
    end
    while (i < nbeats && cyc < 300) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? (is_b ? b_v[i] : a_v[i]) : $urandom;
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (i < nbeats) begin
      errors++;
      $display("FAIL load_timeout beats=%0d want %0d", i, nbeats);
    end
  endtask

  task automatic readout(input int stall_idx, input int abort_at);
    int k = 0, stall = 0, cyc = 0, d0;
    logic [31:0] saved = '0;
    d0 = done_cnt;
    while (k < N && cyc < 600) begin
      out_ready = 1'b1;
      if (out_valid && k == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL abort_out busy=%0b valid=%0b ready=%0b want 0 0 1", busy_o, out_valid, cmd_ready);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (done_cnt !== d0) begin
          errors++;
          $display("FAIL abort_out_done pulses=%0d want %0d", done_cnt, d0);
        end
        exp_c.delete();
        return;
      end
      if (out_valid && k == stall_idx && stall < 5) begin
        out_ready = 1'b0;
        stall++;
        if (stall == 1) saved = out_data;
        checks++;
        if (out_data !== saved || tpu_row !== 2'(stall_idx / DIM) || tpu_col !== 2'(stall_idx % DIM)) begin
          errors++;
          $display("FAIL stall_hold got (%0d,%0d,%0d) want (%0d,%0d,%0d)", tpu_row, tpu_col,
                   out_data, stall_idx / DIM, stall_idx % DIM, saved);
        end
      end
      if (out_valid && out_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (k < N || busy_o !== 1'b0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL readout_end elems=%0d busy=%0b done=%0d want %0d 0 %0d", k, busy_o, done_cnt - d0, N, 1);
    end
  endtask

  task automatic run_job(input bit gaps, input int stall_idx, input int abort_at);
    int s0;
    s0 = start_cnt;
    push_c();
    send_cmd();
    load_mat(1'b0, gaps, N);
    load_mat(1'b1, gaps, N);
    readout(stall_idx, abort_at);
    checks++;
    if (start_cnt !== s0 + 1) begin
      errors++;
      $display("FAIL start_pulses got %0d want 1", start_cnt - s0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy_o !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
        done_o !== 1'b0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl rdy=%0b busy=%0b inr=%0b ov=%0b done=%0b od=%0d want 1 0 0 0 0 0",
               cmd_ready, busy_o, in_ready, out_valid, done_o, out_data);
    end
    checks++;
    if ({tpu_start, tpu_wr_a, tpu_wr_b, tpu_wr_c, tpu_row, tpu_col} !== 8'd0 || tpu_data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_tpu st=%0b wa=%0b wb=%0b wc=%0b r=%0d c=%0d d=%0d want all 0",
               tpu_start, tpu_wr_a, tpu_wr_b, tpu_wr_c, tpu_row, tpu_col, tpu_data_o);
    end
  endtask

  task automatic test_full_job();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'(i);
      b_v[i] = 32'(100 + i);
    end
    run_job(1'b0, -1, -1);
  endtask

  task automatic test_load_gaps();
    int w0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    w0 = wr_a_cnt;
    run_job(1'b1, -1, -1);
    checks++;
    if (wr_a_cnt - w0 !== N || exp_a.size() != 0) begin
      errors++;
      $display("FAIL gap_write_count got %0d want %0d", wr_a_cnt - w0, N);
    end
  endtask

  task automatic test_out_stall();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'($urandom_range(0, 65535));
      b_v[i] = 32'($urandom_range(0, 65535));
    end
    run_job(1'b0, 1 * DIM + 2, -1);
  endtask

  task automatic test_abort();
    int d0;
    cmd_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_cmd busy=%0b want 0", busy_o);
    end
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'(3 * i + 1);
      b_v[i] = 32'(7 * i + 2);
    end
    d0 = done_cnt;
    send_cmd();
    load_mat(1'b0, 1'b0, N);
    load_mat(1'b1, 1'b0, N);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (tpu_start !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_state start=%0b busy=%0b want 1 1", tpu_start, busy_o);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || out_valid !== 1'b0 || tpu_start !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait busy=%0b ov=%0b st=%0b rdy=%0b want 0 0 0 1", busy_o, out_valid, tpu_start, cmd_ready);
    end
    repeat (15) @(posedge clk); #1;
    checks++;
    if (done_cnt !== d0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_quiet done=%0d busy=%0b want %0d 0", done_cnt, busy_o, d0);
    end
    run_job(1'b0, -1, -1);
    run_job(1'b0, -1, 5);
    run_job(1'b0, -1, -1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'(50 + i);
      b_v[i] = 32'(200 - i);
    end
    send_cmd();
    load_mat(1'b0, 1'b0, N);
    load_mat(1'b1, 1'b0, 2 * DIM);
    checks++;
    if (tpu_row !== 2'd2 || tpu_col !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pos r=%0d c=%0d inr=%0b want 2 0 1", tpu_row, tpu_col, in_ready);
    end
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || cmd_ready !== 1'b1 || tpu_row !== 2'd0 || tpu_col !== 2'd0 ||
        tpu_wr_b !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%0b rdy=%0b r=%0d c=%0d wb=%0b inr=%0b want 0 1 0 0 0 0",
               busy_o, cmd_ready, tpu_row, tpu_col, tpu_wr_b, in_ready);
    end
    in_valid = 1'b0;
    exp_b.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      a_v[i] = 32'(9 * i);
      b_v[i] = 32'(i ^ 5);
    end
    run_job(1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_load_gaps();
    test_out_stall();
    test_abort();
    test_reset_mid();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || exp_c.size() != 0) begin
      errors++;
      $display("FAIL leftover a=%0d b=%0d c=%0d want 0 0 0", exp_a.size(), exp_b.size(), exp_c.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
